// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - opcode, state and dispatch definitions for the Mini SRC control unit
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  // ALU code used for every address / branch-target addition
  localparam logic [4:0] ALU_ADD = OP_ADD;

  typedef enum logic [5:0] {
    S_T0, S_T1, S_T2, S_T3,
    S_ALU4, S_ALU5, S_ALU6,
    S_UN4, S_UN5,
    S_MD4, S_MD5, S_MD6, S_MD7,
    S_MEM4, S_MEM5, S_LDI6,
    S_LD6, S_LD7, S_LD8, S_LD9,
    S_ST6, S_ST7, S_ST8,
    S_BR4, S_BR5, S_BR6, S_BR7,
    S_JR4, S_JAL4, S_JAL5,
    S_IN4, S_OUT4, S_MFH4, S_MFL4,
    S_HALT
  } state_t;

  function automatic logic is_imm(input logic [4:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  // First execute state for an opcode; undefined opcodes fall back to T0 like nop
  function automatic state_t dispatch(input logic [4:0] op);
    state_t s;
    s = S_T0;
    if (op == OP_LD || op == OP_LDI || op == OP_ST) s = S_MEM4;
    else if (op >= OP_ADD && op <= OP_ORI)          s = S_ALU4;
    else if (op == OP_MUL || op == OP_DIV)          s = S_MD4;
    else if (op == OP_NEG || op == OP_NOT)          s = S_UN4;
    else if (op == OP_BR)                           s = S_BR4;
    else if (op == OP_JR)                           s = S_JR4;
    else if (op == OP_JAL)                          s = S_JAL4;
    else if (op == OP_IN)                           s = S_IN4;
    else if (op == OP_OUT)                          s = S_OUT4;
    else if (op == OP_MFHI)                         s = S_MFH4;
    else if (op == OP_MFLO)                         s = S_MFL4;
    else if (op == OP_HALT)                         s = S_HALT;
    return s;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - datapath control lines driven by the control unit
interface control_unit_if;
  logic       PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, In_port_out, C_out, MDR_out;
  logic       MAR_enable, MDR_enable, Y_enable, Z_enable, IR_enable, PC_enable;
  logic       HI_enable, LO_enable, CON_enable, out_port_enable;
  logic       Read, RAM_read_enable, RAM_write_enable, IncPC;
  logic       Gra, Grb, Grc, Rin, Rout, BAout, R15_enable;
  logic [4:0] opcode;
  logic       Run;

  modport master (
    output PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, In_port_out, C_out, MDR_out,
    output MAR_enable, MDR_enable, Y_enable, Z_enable, IR_enable, PC_enable,
    output HI_enable, LO_enable, CON_enable, out_port_enable,
    output Read, RAM_read_enable, RAM_write_enable, IncPC,
    output Gra, Grb, Grc, Rin, Rout, BAout, R15_enable, opcode, Run
  );

  modport slave (
    input PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, In_port_out, C_out, MDR_out,
    input MAR_enable, MDR_enable, Y_enable, Z_enable, IR_enable, PC_enable,
    input HI_enable, LO_enable, CON_enable, out_port_enable,
    input Read, RAM_read_enable, RAM_write_enable, IncPC,
    input Gra, Grb, Grc, Rin, Rout, BAout, R15_enable, opcode, Run
  );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/execute sequencer for the Mini SRC datapath
module control_unit
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  clr,
  input  logic [31:0]           IR,
  input  logic                  CON,
  input  logic                  Stop,
  control_unit_if.master        bus
);

  state_t     state_q, state_d;
  logic [4:0] op;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = &{1'b0, IR[26:0]};

  // State register; clr abandons whatever instruction is in flight
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_T0;
    else     state_q <= state_d;
  end

  // Next state; dispatch out of T3 reads the opcode already presented on IR
  always_comb begin
    state_d = S_T0;
    case (state_q)
      S_T0:    state_d = Stop ? S_HALT : S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = dispatch(op);
      S_ALU4:  state_d = S_ALU5;
      S_ALU5:  state_d = S_ALU6;
      S_UN4:   state_d = S_UN5;
      S_MD4:   state_d = S_MD5;
      S_MD5:   state_d = S_MD6;
      S_MD6:   state_d = S_MD7;
      S_MEM4:  state_d = S_MEM5;
      S_MEM5:  state_d = (op == OP_LD) ? S_LD6 : (op == OP_ST) ? S_ST6 : S_LDI6;
      S_LD6:   state_d = S_LD7;
      S_LD7:   state_d = S_LD8;
      S_LD8:   state_d = S_LD9;
      S_ST6:   state_d = S_ST7;
      S_ST7:   state_d = S_ST8;
      S_BR4:   state_d = S_BR5;
      S_BR5:   state_d = S_BR6;
      S_BR6:   state_d = S_BR7;
      S_JAL4:  state_d = S_JAL5;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_T0;
    endcase
  end

  // Moore output decode; everything but Run is held low while clr is asserted
  always_comb begin
    bus.PC_out = 1'b0;          bus.ZHigh_out = 1'b0;       bus.ZLow_out = 1'b0;
    bus.HI_out = 1'b0;          bus.LO_out = 1'b0;          bus.In_port_out = 1'b0;
    bus.C_out = 1'b0;           bus.MDR_out = 1'b0;         bus.MAR_enable = 1'b0;
    bus.MDR_enable = 1'b0;      bus.Y_enable = 1'b0;        bus.Z_enable = 1'b0;
    bus.IR_enable = 1'b0;       bus.PC_enable = 1'b0;       bus.HI_enable = 1'b0;
    bus.LO_enable = 1'b0;       bus.CON_enable = 1'b0;      bus.out_port_enable = 1'b0;
    bus.Read = 1'b0;            bus.RAM_read_enable = 1'b0; bus.RAM_write_enable = 1'b0;
    bus.IncPC = 1'b0;           bus.Gra = 1'b0;             bus.Grb = 1'b0;
    bus.Grc = 1'b0;             bus.Rin = 1'b0;             bus.Rout = 1'b0;
    bus.BAout = 1'b0;           bus.R15_enable = 1'b0;      bus.opcode = 5'b00000;
    bus.Run = (state_q != S_HALT);
    if (!clr) begin
      case (state_q)
        S_T0:   begin bus.PC_out = 1'b1; bus.MAR_enable = 1'b1; bus.IncPC = 1'b1; end
        S_T1:   bus.RAM_read_enable = 1'b1;
        S_T2:   begin bus.Read = 1'b1; bus.MDR_enable = 1'b1; end
        S_T3:   begin bus.MDR_out = 1'b1; bus.IR_enable = 1'b1; end
        S_ALU4: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Y_enable = 1'b1; end
        S_ALU5: begin
          if (is_imm(op)) bus.C_out = 1'b1;
          else begin bus.Grc = 1'b1; bus.Rout = 1'b1; end
          bus.Z_enable = 1'b1; bus.opcode = op;
        end
        S_UN4:  begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Z_enable = 1'b1; bus.opcode = op; end
        S_MD4:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Y_enable = 1'b1; end
        S_MD5:  begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Z_enable = 1'b1; bus.opcode = op; end
        S_MD6:  begin bus.ZLow_out = 1'b1; bus.LO_enable = 1'b1; end
        S_MD7:  begin bus.ZHigh_out = 1'b1; bus.HI_enable = 1'b1; end
        S_MEM4: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Y_enable = 1'b1; end
        S_MEM5, S_BR6: begin bus.C_out = 1'b1; bus.Z_enable = 1'b1; bus.opcode = ALU_ADD; end
        S_ALU6, S_UN5, S_LDI6: begin bus.ZLow_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
        S_LD6, S_ST6: begin bus.ZLow_out = 1'b1; bus.MAR_enable = 1'b1; end
        S_LD7:  bus.RAM_read_enable = 1'b1;
        S_LD8:  begin bus.Read = 1'b1; bus.MDR_enable = 1'b1; end
        S_LD9:  begin bus.MDR_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
        S_ST7:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDR_enable = 1'b1; end
        S_ST8:  begin bus.MDR_out = 1'b1; bus.RAM_write_enable = 1'b1; end
        S_BR4:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CON_enable = 1'b1; end
        S_BR5:  begin bus.PC_out = 1'b1; bus.Y_enable = 1'b1; end
        S_BR7:  begin bus.ZLow_out = 1'b1; bus.PC_enable = CON; end
        S_JR4, S_JAL5: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PC_enable = 1'b1; end
        S_JAL4: begin bus.PC_out = 1'b1; bus.R15_enable = 1'b1; end
        S_IN4:  begin bus.In_port_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
        S_OUT4: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.out_port_enable = 1'b1; end
        S_MFH4: begin bus.HI_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
        S_MFL4: begin bus.LO_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed and randomized checks of the control_unit sequencer
module tb_control_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        clr, CON, Stop;
  logic [31:0] IR;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  control_unit_if ifc();
  control_unit dut (.clk(clk), .clr(clr), .IR(IR), .CON(CON), .Stop(Stop), .bus(ifc));

  localparam logic [34:0] M_PC_OUT = 35'd1 << 0,  M_ZHI_OUT = 35'd1 << 1,  M_ZLO_OUT = 35'd1 << 2;
  localparam logic [34:0] M_HI_OUT = 35'd1 << 3,  M_LO_OUT  = 35'd1 << 4,  M_IN_OUT  = 35'd1 << 5;
  localparam logic [34:0] M_C_OUT  = 35'd1 << 6,  M_MDR_OUT = 35'd1 << 7,  M_MAR_EN  = 35'd1 << 8;
  localparam logic [34:0] M_MDR_EN = 35'd1 << 9,  M_Y_EN    = 35'd1 << 10, M_Z_EN    = 35'd1 << 11;
  localparam logic [34:0] M_IR_EN  = 35'd1 << 12, M_PC_EN   = 35'd1 << 13, M_HI_EN   = 35'd1 << 14;
  localparam logic [34:0] M_LO_EN  = 35'd1 << 15, M_CON_EN  = 35'd1 << 16, M_OUTP_EN = 35'd1 << 17;
  localparam logic [34:0] M_READ   = 35'd1 << 18, M_RAMR    = 35'd1 << 19, M_RAMW    = 35'd1 << 20;
  localparam logic [34:0] M_INCPC  = 35'd1 << 21, M_GRA     = 35'd1 << 22, M_GRB     = 35'd1 << 23;
  localparam logic [34:0] M_GRC    = 35'd1 << 24, M_RIN     = 35'd1 << 25, M_ROUT    = 35'd1 << 26;
  localparam logic [34:0] M_BAOUT  = 35'd1 << 27, M_R15     = 35'd1 << 28, M_RUN     = 35'd1 << 29;

  function automatic logic [34:0] observed();
    return {ifc.opcode, ifc.Run, ifc.R15_enable, ifc.BAout, ifc.Rout, ifc.Rin, ifc.Grc, ifc.Grb,
            ifc.Gra, ifc.IncPC, ifc.RAM_write_enable, ifc.RAM_read_enable, ifc.Read,
            ifc.out_port_enable, ifc.CON_enable, ifc.LO_enable, ifc.HI_enable, ifc.PC_enable,
            ifc.IR_enable, ifc.Z_enable, ifc.Y_enable, ifc.MDR_enable, ifc.MAR_enable, ifc.MDR_out,
            ifc.C_out, ifc.In_port_out, ifc.LO_out, ifc.HI_out, ifc.ZLow_out, ifc.ZHigh_out, ifc.PC_out};
  endfunction

  function automatic logic [34:0] alu(input logic [4:0] code);
    logic [34:0] v;
    v = '0;
    v[34:30] = code;
    return v;
  endfunction

  // Instruction length in cycles, T0 through the last execute step
  function automatic int instr_len(input logic [4:0] op);
    if (op == OP_LD) return 10;
    if (op == OP_ST) return 9;
    if (op == OP_MUL || op == OP_DIV || op == OP_BR) return 8;
    if (op == OP_LDI || (op >= OP_ADD && op <= OP_ORI)) return 7;
    if (op == OP_JAL || op == OP_NEG || op == OP_NOT) return 6;
    if (op >= OP_JR && op <= OP_MFLO) return 5;
    return 4;
  endfunction

  // Expected outputs for step k (0 = T0) of an instruction
  function automatic logic [34:0] model(input logic [4:0] op, input int k, input logic con);
    logic [34:0] v;
    int e;
    v = M_RUN;
    e = k - 4;
    if (k == 0) v |= M_PC_OUT | M_MAR_EN | M_INCPC;
    else if (k == 1) v |= M_RAMR;
    else if (k == 2) v |= M_READ | M_MDR_EN;
    else if (k == 3) v |= M_MDR_OUT | M_IR_EN;
    else if (op >= OP_ADD && op <= OP_ORI) begin
      if (e == 0) v |= M_GRB | M_ROUT | M_Y_EN;
      if (e == 1) v |= M_Z_EN | alu(op) | ((op >= OP_ADDI) ? M_C_OUT : (M_GRC | M_ROUT));
      if (e == 2) v |= M_ZLO_OUT | M_GRA | M_RIN;
    end else if (op == OP_NEG || op == OP_NOT) begin
      if (e == 0) v |= M_GRB | M_ROUT | M_Z_EN | alu(op);
      if (e == 1) v |= M_ZLO_OUT | M_GRA | M_RIN;
    end else if (op == OP_MUL || op == OP_DIV) begin
      if (e == 0) v |= M_GRA | M_ROUT | M_Y_EN;
      if (e == 1) v |= M_GRB | M_ROUT | M_Z_EN | alu(op);
      if (e == 2) v |= M_ZLO_OUT | M_LO_EN;
      if (e == 3) v |= M_ZHI_OUT | M_HI_EN;
    end else if (op == OP_LD || op == OP_LDI || op == OP_ST) begin
      if (e == 0) v |= M_GRB | M_BAOUT | M_Y_EN;
      if (e == 1) v |= M_C_OUT | M_Z_EN | alu(OP_ADD);
      if (e == 2) v |= (op == OP_LDI) ? (M_ZLO_OUT | M_GRA | M_RIN) : (M_ZLO_OUT | M_MAR_EN);
      if (op == OP_LD && e == 3) v |= M_RAMR;
      if (op == OP_LD && e == 4) v |= M_READ | M_MDR_EN;
      if (op == OP_LD && e == 5) v |= M_MDR_OUT | M_GRA | M_RIN;
      if (op == OP_ST && e == 3) v |= M_GRA | M_ROUT | M_MDR_EN;
      if (op == OP_ST && e == 4) v |= M_MDR_OUT | M_RAMW;
    end else if (op == OP_BR) begin
      if (e == 0) v |= M_GRA | M_ROUT | M_CON_EN;
      if (e == 1) v |= M_PC_OUT | M_Y_EN;
      if (e == 2) v |= M_C_OUT | M_Z_EN | alu(OP_ADD);
      if (e == 3) v |= M_ZLO_OUT | (con ? M_PC_EN : 35'd0);
    end else if (op == OP_JR)   v |= M_GRA | M_ROUT | M_PC_EN;
    else if (op == OP_JAL)      v |= (e == 0) ? (M_PC_OUT | M_R15) : (M_GRA | M_ROUT | M_PC_EN);
    else if (op == OP_IN)       v |= M_IN_OUT | M_GRA | M_RIN;
    else if (op == OP_OUT)      v |= M_GRA | M_ROUT | M_OUTP_EN;
    else if (op == OP_MFHI)     v |= M_HI_OUT | M_GRA | M_RIN;
    else if (op == OP_MFLO)     v |= M_LO_OUT | M_GRA | M_RIN;
    return v;
  endfunction

  task automatic check(input string tag, input logic [34:0] exp);
    logic [34:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at the falling edge inside T0; checks n steps, ending inside step n-1.
  // con_mode 0/1 forces CON, 2 randomizes it every cycle; Stop is random outside T0.
  task automatic run_steps(input logic [4:0] op, input int con_mode, input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) begin
        IR   = {op, 27'($urandom)};
        Stop = 1'b0;
      end else begin
        Stop = 1'($urandom);
      end
      CON = (con_mode == 2) ? 1'($urandom) : con_mode[0];
      #1;
      check($sformatf("op%0d_step%0d", op, k), model(op, k, CON));
    end
  endtask

  task automatic run_instr(input logic [4:0] op, input int con_mode);
    run_steps(op, con_mode, instr_len(op));
    @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    #1;
    check("clr_hold", M_RUN);
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] op;
    clr = 1'b1; IR = '0; CON = 1'b0; Stop = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset", M_RUN);
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);

    run_instr(OP_ADD, 2);
    run_instr(OP_ORI, 2);
    run_instr(OP_BR, 0);
    run_instr(OP_BR, 1);
    run_instr(OP_LD, 2);
    run_instr(OP_ST, 2);
    run_instr(OP_MUL, 2);
    run_instr(OP_LDI, 2);
    run_instr(OP_JAL, 2);
    run_instr(OP_NOP, 2);
    run_instr(5'b11111, 2);

    // clr during ld T7 abandons the load and restarts fetch
    run_steps(OP_LD, 2, 8);
    do_clr();
    run_instr(OP_NEG, 2);

    // halt parks the sequencer until clr
    run_steps(OP_HALT, 2, 4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      Stop = 1'($urandom);
      CON  = 1'($urandom);
      #1;
      check($sformatf("halt_c%0d", i), 35'd0);
    end
    do_clr();
    run_instr(OP_SUB, 2);

    // Stop seen in T0 halts before any further fetch strobe
    IR = {OP_ADD, 27'd0};
    Stop = 1'b1;
    #1;
    check("stop_t0", model(OP_ADD, 0, CON));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("stop_halt_c%0d", i), 35'd0);
    end
    Stop = 1'b0;
    do_clr();

    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == OP_HALT) op = OP_NOP;
      run_instr(op, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
